// File: rtl/dbus_uart_pkg.sv
// Shared register map, STATUS bit layout and serializer state type
// for the data-bus UART transmitter.
package dbus_uart_pkg;

  localparam logic [1:0] REG_DATA   = 2'd0;
  localparam logic [1:0] REG_STATUS = 2'd1;
  localparam logic [1:0] REG_CTRL   = 2'd2;

  localparam int STAT_FULL    = 0;
  localparam int STAT_EMPTY   = 1;
  localparam int STAT_BUSY    = 2;
  localparam int STAT_OVF     = 3;
  localparam int STAT_CNT_LSB = 8;

  typedef enum logic [1:0] {
    IDLE,
    START,
    DATA,
    STOP
  } tx_state_t;

endpackage

// File: rtl/uart_fifo.sv
// Byte FIFO feeding the UART serializer; pointers carry an extra
// wrap bit so full and empty are distinguished without a counter.
module uart_fifo #(
  parameter int DEPTH = 16,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          push_i,
  input  logic [7:0]    din_i,
  input  logic          pop_i,
  output logic [7:0]    dout_o,
  output logic          full_o,
  output logic          empty_o,
  output logic [AW:0]   count_o
);

  logic [7:0]  mem_q [DEPTH];
  logic [AW:0] wr_q, wr_d;
  logic [AW:0] rd_q, rd_d;
  logic        do_push;
  logic        do_pop;

  assign empty_o = (wr_q == rd_q);
  assign full_o  = (wr_q[AW] != rd_q[AW]) &&
                   (wr_q[AW-1:0] == rd_q[AW-1:0]);
  assign count_o = wr_q - rd_q;
  assign dout_o  = mem_q[rd_q[AW-1:0]];

  // a pop in the same cycle frees the slot a full push needs
  assign do_pop  = pop_i && !empty_o;
  assign do_push = push_i && (!full_o || do_pop);

  always_comb begin
    wr_d = wr_q;
    rd_d = rd_q;
    if (do_push) wr_d = wr_q + 1'b1;
    if (do_pop)  rd_d = rd_q + 1'b1;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_q <= '0;
      rd_q <= '0;
    end else begin
      wr_q <= wr_d;
      rd_q <= rd_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_q[AW-1:0]] <= din_i;
  end

endmodule

// File: rtl/dbus_uart_tx.sv
// Data-bus UART transmitter: register decode, transmit FIFO and an
// 8N1 serializer with back-to-back frame chaining.
module dbus_uart_tx
  import dbus_uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = 868,
  parameter int FIFO_DEPTH   = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        sel,
  input  logic [1:0]  adr,
  input  logic [15:0] dat_o,
  input  logic        we,
  input  logic        re,
  output logic [15:0] dat_i,
  output logic        txd,
  output logic        irq
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] BAUD_LAST = CW'(CLKS_PER_BIT - 1);

  tx_state_t     state_q, state_d;
  logic [CW-1:0] baud_q, baud_d;
  logic [2:0]    bit_q, bit_d;
  logic [7:0]    shift_q, shift_d;
  logic [15:0]   dat_q, dat_d;
  logic          ie_q, ie_d;
  logic          ovf_q, ovf_d;
  logic          irq_q, irq_d;
  logic          txd_c;

  logic          wr_acc, rd_acc;
  logic          fifo_push, fifo_pop;
  logic [7:0]    fifo_dout;
  logic          fifo_full, fifo_empty;
  logic [AW:0]   fifo_count;
  logic          baud_done;
  logic          busy;
  logic [15:0]   status;

  uart_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .reset   (reset),
    .push_i  (fifo_push),
    .din_i   (dat_o[7:0]),
    .pop_i   (fifo_pop),
    .dout_o  (fifo_dout),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .count_o (fifo_count)
  );

  // a simultaneous write and read is treated as a write only
  assign wr_acc    = sel && we;
  assign rd_acc    = sel && re && !we;
  assign fifo_push = wr_acc && (adr == REG_DATA);
  assign busy      = (state_q != IDLE);
  assign baud_done = (baud_q == BAUD_LAST);

  always_comb begin
    status                       = '0;
    status[STAT_FULL]            = fifo_full;
    status[STAT_EMPTY]           = fifo_empty;
    status[STAT_BUSY]            = busy;
    status[STAT_OVF]             = ovf_q;
    status[STAT_CNT_LSB +: 8]    = 8'(fifo_count);
  end

  always_comb begin
    dat_d = dat_q;
    ie_d  = ie_q;
    ovf_d = ovf_q;
    if (rd_acc) begin
      unique case (adr)
        REG_STATUS: dat_d = status;
        REG_CTRL:   dat_d = {15'd0, ie_q};
        default:    dat_d = '0;
      endcase
    end
    if (wr_acc && adr == REG_CTRL) ie_d = dat_o[0];
    if (rd_acc && adr == REG_STATUS) ovf_d = 1'b0;
    // a dropped push wins over the clear-on-read
    if (fifo_push && fifo_full && !fifo_pop) ovf_d = 1'b1;
    irq_d = ie_q && fifo_empty && !busy;
  end

  always_comb begin
    state_d  = state_q;
    baud_d   = baud_q;
    bit_d    = bit_q;
    shift_d  = shift_q;
    fifo_pop = 1'b0;
    txd_c    = 1'b1;
    unique case (state_q)
      IDLE: begin
        if (!fifo_empty) begin
          fifo_pop = 1'b1;
          shift_d  = fifo_dout;
          baud_d   = '0;
          state_d  = START;
        end
      end
      START: begin
        txd_c = 1'b0;
        if (baud_done) begin
          baud_d  = '0;
          bit_d   = '0;
          state_d = DATA;
        end else begin
          baud_d = baud_q + 1'b1;
        end
      end
      DATA: begin
        txd_c = shift_q[bit_q];
        if (baud_done) begin
          baud_d = '0;
          bit_d  = bit_q + 1'b1;
          if (bit_q == 3'd7) state_d = STOP;
        end else begin
          baud_d = baud_q + 1'b1;
        end
      end
      STOP: begin
        if (baud_done) begin
          baud_d = '0;
          if (!fifo_empty) begin
            fifo_pop = 1'b1;
            shift_d  = fifo_dout;
            state_d  = START;
          end else begin
            state_d = IDLE;
          end
        end else begin
          baud_d = baud_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      baud_q  <= '0;
      bit_q   <= '0;
      shift_q <= '0;
      dat_q   <= '0;
      ie_q    <= 1'b0;
      ovf_q   <= 1'b0;
      irq_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      baud_q  <= baud_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
      dat_q   <= dat_d;
      ie_q    <= ie_d;
      ovf_q   <= ovf_d;
      irq_q   <= irq_d;
    end
  end

  // decoded from state so reset drives the line high without a clock
  assign txd   = txd_c;
  assign dat_i = dat_q;
  assign irq   = irq_q;

endmodule

// File: doc/dbus_uart_tx.md
# dbus_uart_tx

Memory-mapped UART transmitter that acts as a responder on the J1 core's data bus (`if_dbus`), alongside the data SPRAM. The core writes bytes into a small FIFO through a data register; a serializer drains the FIFO onto `txd` as 8N1 frames. Status and control registers give the core polled or interrupt-driven flow control.

## Interface
- `CLKS_PER_BIT`, default 868: clock cycles per serial bit, giving 115200 baud at 100 MHz; must be ≥ 2.
- `FIFO_DEPTH`, default 16: transmit FIFO entries; must be a power of 2 and ≥ 2.

Ports:
- `clk`  in  1  single system clock, rising edge.
- `reset`  in  1  asynchronous, active-high.
- `sel`  in  1  block select, decoded from `dbus.adr` at top level.
- `adr`  in  2  register offset (`dbus.adr[1:0]`).
- `dat_o`  in  16  write data from the core.
- `we`  in  1  write strobe; effective only when `sel` is high.
- `re`  in  1  read strobe; effective only when `sel` is high.
- `dat_i`  out  16  registered read data to the core.
- `txd`  out  1  serial output, idle high.
- `irq`  out  1  level interrupt, registered.

## Operation
- Register map, by `adr`:
  - 0 DATA: a write pushes `dat_o[7:0]`; a read returns 0.
  - 1 STATUS: bit0 full, bit1 empty, bit2 busy (serializer not IDLE), bit3 overflow (sticky); bits[15:8] hold the FIFO count; all other bits 0.
  - 2 CTRL: bit0 irq enable; read/write; all other bits read 0.
  - 3: reserved; reads 0, writes are ignored.
- If `we` and `re` are both high in one cycle, the access is a write and `dat_i` holds its previous value.
- A DATA write while full is dropped and sets overflow, unless a pop happens in the same cycle, in which case the push is accepted.
- A STATUS read clears overflow after the snapshot is captured. If an overflow event happens in the same cycle as the read, overflow stays set.
- Serializer FSM states:
  - IDLE: `txd`=1. If the FIFO is non-empty, pop one byte, go to START.
  - START: `txd`=0 for `CLKS_PER_BIT` cycles, then go to DATA.
  - DATA: 8 bits, LSB first, each `CLKS_PER_BIT` cycles; a 3-bit index is used. After bit 7, go to STOP.
  - STOP: `txd`=1 for `CLKS_PER_BIT` cycles. If the FIFO is non-empty at the last stop cycle, pop and go directly to START (no idle gap); otherwise go to IDLE.
- `irq` = CTRL.ie & empty & !busy, registered.

## Timing
- Reset values:
  - outputs: `dat_i`=0, `txd`=1, `irq`=0.
  - internal: FIFO empty, CTRL=0, overflow=0, FSM in IDLE, bit counter 0.
- Read latency is 1 cycle: `dat_i` is valid in the cycle after `sel&re` and is held until the next read.
- Write effects are visible to a STATUS read issued on the next cycle.
- Push-to-start latency: a DATA write at edge n into an empty FIFO with the FSM in IDLE makes the FIFO non-empty after edge n. The pop happens at edge n+1 and `txd` falls after edge n+1.
- Each frame lasts exactly 10·`CLKS_PER_BIT` cycles; back-to-back frames are contiguous.
- Reset asserted mid-frame forces `txd` high immediately (asynchronously) and discards FIFO contents.

## Structure
- Package `dbus_uart_pkg` holds:
  - register offset constants (`REG_DATA`, `REG_STATUS`, `REG_CTRL`);
  - STATUS bit-position constants;
  - the `tx_state_t` enum (IDLE, START, DATA, STOP).
- One sub-module, `uart_fifo`: a synchronous 8-bit-wide FIFO of `FIFO_DEPTH` entries with push/pop/full/empty/count.
  - Pointers are one bit wider than the address.
  - Push and pop in the same cycle while full are both accepted.
- The top level holds the register decode, the baud counter and the FSM.

## Test plan
All scenarios use `CLKS_PER_BIT`=4 and `FIFO_DEPTH`=4.
- Reset, then read STATUS -> `dat_i`=0x0002 one cycle later; `txd`=1 and `irq`=0 throughout.
- Write 0xA5 to DATA -> `txd` sequence (4 cycles each) 0,1,0,1,0,0,1,0,1,1; total 40 cycles; STATUS bit2 is 1 during the frame and 0 after.
- Write 0x01, 0x02, 0x03 back-to-back -> three contiguous frames (120 cycles, no idle between stop and next start); STATUS count reads 2 just after the first pop.
- With the serializer stalled mid-frame, write 0x10–0x14 to fill the FIFO -> the 5th write sets overflow. Reading STATUS returns bit3=1 and bits[15:8]=4; an immediate second read returns bit3=0.
- Set CTRL=1, write 0x55 -> `irq` is 0 during the frame and rises after the stop bit completes; writing CTRL=0 drops `irq` the next cycle.
- Assert `reset` at cycle 10 of a frame -> `txd`=1 within the reset cycle without waiting for a clock edge; after release, STATUS=0x0002 and no residual frame is sent.
